// File: rtl/package_settings.sv
// Shared widths and types for the ADC-side filter chain and its test-stimulus source.
package package_settings;

    localparam int SIZE_ADC_DATA       = 14;
    localparam int SIZE_TEST_RAM_ADDR  = 7;
    localparam int SIZE_TEST_COUNTER   = 16;
    localparam int SIZE_TEST_RAM_DEPTH = 2**SIZE_TEST_RAM_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } tsg_state_t;

endpackage

// File: rtl/test_ram_dp.sv
// Simple dual-port waveform RAM: one write port, one registered read port.
// A read of an address being written in the same cycle returns the old data.
module test_ram_dp
    import package_settings::*;
#(
    parameter int ADDR_W = SIZE_TEST_RAM_ADDR,
    parameter int DATA_W = SIZE_ADC_DATA
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/test_signal_gen.sv
// Plays a test-RAM waveform as an ADC sample stream with programmable gap and
// pulse count; stands in for the ADC input of the trapezoidal filter.
module test_signal_gen
    import package_settings::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [SIZE_TEST_RAM_ADDR-1:0] wr_addr,
    input  logic [SIZE_ADC_DATA-1:0]      wr_data,
    input  logic [SIZE_TEST_RAM_ADDR-1:0] last_addr,
    input  logic [SIZE_TEST_COUNTER-1:0]  gap_len,
    input  logic [SIZE_TEST_COUNTER-1:0]  n_pulses,
    input  logic [SIZE_ADC_DATA-1:0]      baseline,
    input  logic                          start,
    input  logic                          stop,
    output logic [SIZE_ADC_DATA-1:0]      adc_data,
    output logic                          data_valid,
    output logic                          busy,
    output logic [SIZE_TEST_COUNTER-1:0]  pulse_cnt,
    output logic                          done
);

    tsg_state_t state, state_next;

    logic [SIZE_TEST_RAM_ADDR-1:0] play_addr, play_addr_next;
    logic [SIZE_TEST_COUNTER-1:0]  gap_cnt, gap_cnt_next;
    logic [SIZE_TEST_COUNTER-1:0]  cnt_next, cnt_sat;
    logic                          done_next;
    logic                          load_cfg;
    logic                          abort;

    logic [SIZE_TEST_RAM_ADDR-1:0] last_l;
    logic [SIZE_TEST_COUNTER-1:0]  gap_l;
    logic [SIZE_TEST_COUNTER-1:0]  n_l;
    logic [SIZE_ADC_DATA-1:0]      base_l;

    logic [SIZE_TEST_RAM_ADDR-1:0] rd_addr;
    logic                          v_addr;
    logic [SIZE_ADC_DATA-1:0]      ram_q;
    logic                          v_ram;

    test_ram_dp #(
        .ADDR_W(SIZE_TEST_RAM_ADDR),
        .DATA_W(SIZE_ADC_DATA)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );

    assign abort   = stop && (state != ST_IDLE);
    assign cnt_sat = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + 1'b1;

    always_comb begin
        state_next     = state;
        play_addr_next = play_addr;
        gap_cnt_next   = gap_cnt;
        cnt_next       = pulse_cnt;
        done_next      = 1'b0;
        load_cfg       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next     = ST_PLAY;
                    play_addr_next = '0;
                    cnt_next       = '0;
                    load_cfg       = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (play_addr == last_l) begin
                    cnt_next = cnt_sat;
                    if ((n_l != '0) && (cnt_sat == n_l)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (gap_l == '0) begin
                        play_addr_next = '0;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = '0;
                    end
                end else begin
                    play_addr_next = play_addr + 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt == gap_l - 1'b1) begin
                    state_next     = ST_PLAY;
                    play_addr_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            play_addr  <= '0;
            gap_cnt    <= '0;
            pulse_cnt  <= '0;
            done       <= 1'b0;
            last_l     <= '0;
            gap_l      <= '0;
            n_l        <= '0;
            base_l     <= '0;
            rd_addr    <= '0;
            v_addr     <= 1'b0;
            v_ram      <= 1'b0;
            adc_data   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_next;
            play_addr <= play_addr_next;
            gap_cnt   <= gap_cnt_next;
            pulse_cnt <= cnt_next;
            done      <= done_next;
            if (load_cfg) begin
                last_l <= last_addr;
                gap_l  <= gap_len;
                n_l    <= n_pulses;
                base_l <= baseline;
            end
            // PLAY tag travels with the address so gap/idle samples become baseline;
            // an abort clears every stage so no stale RAM data leaks out.
            rd_addr    <= play_addr;
            v_addr     <= (state == ST_PLAY) && !abort;
            v_ram      <= v_addr && !abort;
            adc_data   <= (v_ram && !abort) ? ram_q : base_l;
            data_valid <= (state != ST_IDLE) && !abort;
            busy       <= (state != ST_IDLE) && !abort;
        end
    end

endmodule

// File: tb/tb_test_signal_gen.sv
// Scoreboard bench for test_signal_gen: expected streams are derived from the
// configured pulse shape and compared cycle by cycle against the DUT.
module tb_test_signal_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [13:0] wr_data;
    logic [6:0]  last_addr;
    logic [15:0] gap_len;
    logic [15:0] n_pulses;
    logic [13:0] baseline;
    logic        start;
    logic        stop;
    logic [13:0] adc_data;
    logic        data_valid;
    logic        busy;
    logic [15:0] pulse_cnt;
    logic        done;

    typedef struct {
        logic [13:0] data;
        logic        valid;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    logic [13:0] model [128];
    int          tests_run    = 0;
    int          tests_failed = 0;

    test_signal_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .last_addr (last_addr),
        .gap_len   (gap_len),
        .n_pulses  (n_pulses),
        .baseline  (baseline),
        .start     (start),
        .stop      (stop),
        .adc_data  (adc_data),
        .data_valid(data_valid),
        .busy      (busy),
        .pulse_cnt (pulse_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ram(input logic [6:0] a, input logic [13:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    // Start a run and score every output cycle until the pipeline has drained.
    // wr_k > 0 schedules a RAM write landing on the edge after cycle wr_k.
    task automatic run_pulses(input logic [6:0] la, input logic [15:0] gl, input logic [15:0] np,
                              input logic [13:0] bl, input int wr_k,
                              input logic [6:0] wa, input logic [13:0] wd);
        int   p, kk, j, m;
        int   done_seen;
        exp_t e;
        last_addr = la; gap_len = gl; n_pulses = np; baseline = bl;
        start = 1'b1;
        tick();
        start = 1'b0;
        p  = int'(la) + 1 + int'(gl);
        kk = int'(np) * p - int'(gl) + 2;
        for (int k = 1; k <= kk; k++) begin
            if (k < 3) begin
                e.data = bl;
            end else begin
                j = k - 3;
                m = j % p;
                e.data = (m <= int'(la)) ? model[m] : bl;
            end
            e.valid = (k <= kk - 2);
            e.done  = (k == kk - 2);
            sb.push_back(e);
        end
        done_seen = 0;
        for (int k = 1; sb.size() > 0; k++) begin
            tick();
            wr_en = 1'b0;
            e = sb.pop_front();
            check_val("adc_data", 32'(adc_data), 32'(e.data));
            check_val("data_valid", 32'(data_valid), 32'(e.valid));
            check_val("busy", 32'(busy), 32'(e.valid));
            check_val("done", 32'(done), 32'(e.done));
            if (done) done_seen++;
            if (k == wr_k) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            end
        end
        check_val("done_count", 32'(done_seen), 32'd1);
        check_val("pulse_cnt_end", 32'(pulse_cnt), 32'(np));
        if (wr_k > 0) model[wa] = wd;
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_addr = '0; gap_len = '0; n_pulses = '0; baseline = '0;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 128; i++) model[i] = '0;
        tick(); tick();
        check_val("rst_adc_data", 32'(adc_data), 32'd0);
        check_val("rst_data_valid", 32'(data_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) write_ram(7'(i), 14'(i * 100));

        // Two pulses of 4 samples with a 2-cycle gap
        run_pulses(7'd3, 16'd2, 16'd2, 14'd50, 0, '0, '0);
        tick(); tick();
        check_val("idle_baseline", 32'(adc_data), 32'd50);

        // Stop mid-PLAY at address 2
        last_addr = 7'd5; gap_len = 16'd2; n_pulses = 16'd3; baseline = 14'd7;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check_val("stop_busy", 32'(busy), 32'd0);
        check_val("stop_data_valid", 32'(data_valid), 32'd0);
        check_val("stop_pulse_cnt", 32'(pulse_cnt), 32'd0);
        check_val("stop_done", 32'(done), 32'd0);
        check_val("stop_adc_data", 32'(adc_data), 32'd7);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("stop_no_done", 32'(done), 32'd0);
            check_val("stop_flushed", 32'(adc_data), 32'd7);
        end
        run_pulses(7'd5, 16'd2, 16'd3, 14'd7, 0, '0, '0);

        // start and stop together: stays idle
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check_val("ss_busy", 32'(busy), 32'd0);
        check_val("ss_data_valid", 32'(data_valid), 32'd0);
        tick();
        check_val("ss_busy2", 32'(busy), 32'd0);
        check_val("ss_pulse_cnt", 32'(pulse_cnt), 32'd3);

        // Write RAM[1] on the edge that reads address 1: old data, then new data
        run_pulses(7'd3, 16'd2, 16'd1, 14'd50, 2, 7'd1, 14'h1234);
        run_pulses(7'd3, 16'd2, 16'd1, 14'd50, 0, '0, '0);

        // Reset during GAP
        last_addr = 7'd3; gap_len = 16'd4; n_pulses = 16'd2; baseline = 14'd9;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check_val("rgap_adc_data", 32'(adc_data), 32'd0);
        check_val("rgap_data_valid", 32'(data_valid), 32'd0);
        check_val("rgap_busy", 32'(busy), 32'd0);
        check_val("rgap_pulse_cnt", 32'(pulse_cnt), 32'd0);
        check_val("rgap_done", 32'(done), 32'd0);
        tick();
        check_val("rgap_idle", 32'(busy), 32'd0);
        run_pulses(7'd3, 16'd4, 16'd2, 14'd9, 0, '0, '0);

        // Continuous single-sample pulses, pulse_cnt saturation
        write_ram(7'd0, 14'h3FFF);
        last_addr = 7'd0; gap_len = 16'd0; n_pulses = 16'd0; baseline = 14'd5;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 65540; k++) begin
            tick();
            if (k inside {1, 2, 3, 100, 65534, 65535, 65536, 65540}) begin
                check_val("sat_pulse_cnt", 32'(pulse_cnt), (k > 65535) ? 32'd65535 : 32'(k));
                check_val("sat_adc_data", 32'(adc_data), (k < 3) ? 32'd5 : 32'h3FFF);
                check_val("sat_data_valid", 32'(data_valid), 32'd1);
                check_val("sat_done", 32'(done), 32'd0);
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check_val("sat_stop_busy", 32'(busy), 32'd0);
        check_val("sat_stop_cnt", 32'(pulse_cnt), 32'd65535);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
